// File: rtl/keycode_router_if.sv
// keycode_router_if: report-byte bus from the USB HID host side into the keycode router.
interface keycode_router_if;
   logic       report_wr;
   logic [2:0] report_idx;
   logic [7:0] report_byte;
   logic       report_done;
   modport master (output report_wr, report_idx, report_byte, report_done);
   modport slave  (input  report_wr, report_idx, report_byte, report_done);
endinterface

// File: rtl/keycode_router.sv
// keycode_router: stages HID reports, commits them atomically and, once per frame,
// resolves each player's movement key and edge-triggered fire pulse.
module keycode_router (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   frame_clk,
   keycode_router_if.slave        rpt,
   output logic [7:0]             keycode_p1,
   output logic [7:0]             keycode_p2,
   output logic                   fire_p1,
   output logic                   fire_p2,
   output logic                   report_err
);
   localparam logic [7:0] P1_FIRE = 8'h58;
   localparam logic [7:0] P2_FIRE = 8'h2C;

   logic [7:0] staging [6];
   logic [7:0] active  [6];
   logic [7:0] merged  [6];
   logic       rollover, idx_ok;
   logic       frame_d, frame_pulse;
   logic       held1, held2, hold1, hold2, edge1, edge2;
   logic [7:0] mv1, mv2;

   function automatic logic is_p1_mv(input logic [7:0] b);
      return b inside {8'h1A, 8'h16, 8'h04, 8'h07};
   endfunction

   function automatic logic is_p2_mv(input logic [7:0] b);
      return b inside {8'h52, 8'h51, 8'h50, 8'h4F};
   endfunction

   assign idx_ok = rpt.report_idx < 3'd6;

   // A byte written in the commit cycle is folded into the committed report.
   always_comb begin
      merged   = staging;
      rollover = 1'b1;
      if (rpt.report_wr && idx_ok) merged[rpt.report_idx] = rpt.report_byte;
      for (int i = 0; i < 6; i++) rollover = rollover & (merged[i] == 8'h01);
   end

   // Descending scan so the lowest matching slot is the one that sticks.
   always_comb begin
      mv1   = 8'h00;
      mv2   = 8'h00;
      hold1 = 1'b0;
      hold2 = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         mv1   = is_p1_mv(active[i]) ? active[i] : mv1;
         mv2   = is_p2_mv(active[i]) ? active[i] : mv2;
         hold1 = hold1 | (active[i] == P1_FIRE);
         hold2 = hold2 | (active[i] == P2_FIRE);
      end
      edge1 = hold1 & ~held1;
      edge2 = hold2 & ~held2;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 6; i++) begin
            staging[i] <= 8'h00;
            active[i]  <= 8'h00;
         end
         frame_d     <= 1'b1;
         frame_pulse <= 1'b0;
         held1       <= 1'b0;
         held2       <= 1'b0;
         keycode_p1  <= 8'h00;
         keycode_p2  <= 8'h00;
         fire_p1     <= 1'b0;
         fire_p2     <= 1'b0;
         report_err  <= 1'b0;
      end else begin
         frame_d     <= frame_clk;
         frame_pulse <= frame_clk & ~frame_d;
         for (int i = 0; i < 6; i++) begin
            staging[i] <= rpt.report_done ? 8'h00 : merged[i];
            if (rpt.report_done && !rollover) active[i] <= merged[i];
         end
         if ((rpt.report_wr && !idx_ok) || (rpt.report_done && rollover)) report_err <= 1'b1;
         // Evaluation reads the pre-commit active buffer when a commit coincides.
         if (frame_pulse) begin
            held1      <= hold1;
            held2      <= hold2;
            fire_p1    <= edge1;
            fire_p2    <= edge2;
            keycode_p1 <= edge1 ? P1_FIRE : mv1;
            keycode_p2 <= edge2 ? P2_FIRE : mv2;
         end else begin
            fire_p1 <= 1'b0;
            fire_p2 <= 1'b0;
         end
      end
   end
endmodule
